// File: rtl/tpsram_stream_reader_if.sv
// Bus bundle between the two-port RAM read sequencer and its neighbours
// (command side, RAM read port, downstream byte stream).
interface tpsram_stream_reader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              START;
    logic [ADDR_W-1:0] BASE_ADDR;
    logic [ADDR_W:0]   LEN;
    logic              BUSY;
    logic              DONE;
    logic [ADDR_W-1:0] RADDR;
    logic              REN;
    logic [DATA_W-1:0] RD;
    logic [DATA_W-1:0] DOUT;
    logic              DOUT_VALID;
    logic              DOUT_READY;
    logic [DATA_W-1:0] CSUM;

    // Stream handshake: a byte moves on any edge with DOUT_VALID=1 and
    // DOUT_READY=1; once raised, DOUT_VALID and DOUT hold until that edge,
    // and DOUT_VALID never looks at DOUT_READY combinationally.
    modport master (
        input  START, BASE_ADDR, LEN, RD, DOUT_READY,
        output BUSY, DONE, RADDR, REN, DOUT, DOUT_VALID, CSUM
    );

    modport slave (
        output START, BASE_ADDR, LEN, RD, DOUT_READY,
        input  BUSY, DONE, RADDR, REN, DOUT, DOUT_VALID, CSUM
    );
endinterface

// File: rtl/tpsram_stream_reader.sv
// Streams LEN bytes from a 64x8 two-port RAM onto a valid/ready byte stream.
// Optional running byte sum on CSUM when TPSRAM_RD_CSUM_EN is defined.
module tpsram_stream_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    tpsram_stream_reader_if.master        bus,
    output logic [1:0]                    dbg_state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   deliver_left;
    logic              rd_pending;
    logic              done_q;

    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;

    logic              ren;
    logic              accept;
    logic              start_ok;
    logic [2:0]        used;

    // Credit covers both buffered bytes and the read still in the RAM pipe,
    // so the FIFO can never be written while full.
    assign used     = count + {2'b00, rd_pending};
    assign ren      = (state == ISSUE) && (used < 3'd4);
    assign accept   = (count != 3'd0) && bus.DOUT_READY;
    assign start_ok = (state == IDLE) && bus.START;

    assign bus.REN        = ren;
    assign bus.RADDR      = addr;
    assign bus.BUSY       = (state != IDLE);
    assign bus.DONE       = done_q;
    assign bus.DOUT       = fifo_mem[rd_ptr];
    assign bus.DOUT_VALID = (count != 3'd0);
    assign dbg_state      = state;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state        <= IDLE;
            addr         <= '0;
            issue_left   <= '0;
            deliver_left <= '0;
            rd_pending   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_pending <= ren;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        if (bus.LEN != '0) begin
                            addr         <= bus.BASE_ADDR;
                            issue_left   <= bus.LEN;
                            deliver_left <= bus.LEN;
                            state        <= ISSUE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (ren) begin
                        addr       <= addr + 1'b1;
                        issue_left <= issue_left - CNT_ONE;
                        if (issue_left == CNT_ONE) state <= DRAIN;
                    end
                end
                DRAIN: ;
                default: state <= IDLE;
            endcase
            // The final byte is always accepted in DRAIN, so this never
            // competes with the ISSUE->DRAIN move above.
            if (accept && state != IDLE) begin
                deliver_left <= deliver_left - CNT_ONE;
                if (deliver_left == CNT_ONE) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (rd_pending) begin
                fifo_mem[wr_ptr] <= bus.RD;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (accept) rd_ptr <= rd_ptr + 1'b1;
            case ({rd_pending, accept})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef TPSRAM_RD_CSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            csum <= '0;
        end else if (start_ok) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + fifo_mem[rd_ptr];
        end
    end

    assign bus.CSUM = csum;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign bus.CSUM        = '0;
`endif
endmodule

// File: tb/tb_tpsram_stream_reader.sv
// Scoreboard bench for tpsram_stream_reader: directed transfers against a
// behavioural 64x8 RAM preloaded with addr+0x10.
module tb_tpsram_stream_reader;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [1:0] dbg_state;

    tpsram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    tpsram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    logic [7:0] ram [64];
    always @(posedge CLK) if (bus.REN) bus.RD <= ram[bus.RADDR];

    int ecnt = 0;
    always @(posedge CLK) ecnt <= ecnt + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_issued = 0;
    int n_accepted = 0;
    logic [7:0] exp_q[$];
    logic [5:0] exp_addr_q[$];
    logic [3:0] pat = 4'b1001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [5:0] a, input logic [7:0] d);
        exp_addr_q.push_back(a);
        exp_q.push_back(d);
    endtask

    task automatic push_xfer(input logic [5:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [5:0] a;
            a = base + 6'(i);
            push_byte(a, 8'(a) + 8'h10);
        end
    endtask

    task automatic monitor();
        logic pv, pr;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b0; pd = '0;
        forever begin
            @(negedge CLK);
            if (!RESETN) begin
                pv = 1'b0;
                n_issued = n_accepted;
                continue;
            end
            if (bus.REN) begin
                n_issued++;
                if (exp_addr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_read: RADDR=0x%0h, expected no read", bus.RADDR);
                end else begin
                    check("raddr", 32'(bus.RADDR), 32'(exp_addr_q.pop_front()));
                end
                check("outstanding_le_4", 32'(n_issued - n_accepted <= 4), 32'd1);
            end
            if (pv && !pr) begin
                check("stall_valid", 32'(bus.DOUT_VALID), 32'd1);
                check("stall_dout", 32'(bus.DOUT), 32'(pd));
            end
            if (bus.DOUT_VALID && bus.DOUT_READY) begin
                n_accepted++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_byte: DOUT=0x%0h, expected no byte", bus.DOUT);
                end else begin
                    check("dout", 32'(bus.DOUT), 32'(exp_q.pop_front()));
                end
            end
            pv = bus.DOUT_VALID;
            pr = bus.DOUT_READY;
            pd = bus.DOUT;
        end
    endtask

    // Returns just after edge k, where START was sampled.
    task automatic start_xfer(input logic [5:0] base, input logic [6:0] len,
                              input bit now, output int k);
        if (!now) begin
            @(posedge CLK); #1;
        end
        bus.START = 1'b1;
        bus.BASE_ADDR = base;
        bus.LEN = len;
        @(posedge CLK); #1;
        k = ecnt;
        bus.START = 1'b0;
    endtask

    // Returns at the negedge inside the DONE cycle.
    task automatic wait_done(input int k, input int n, input bit toggle);
        bit seen;
        int i;
        seen = 1'b0;
        i = 0;
        while (!seen && i < 400) begin
            @(negedge CLK);
            if (bus.DONE) seen = 1'b1;
            else begin
                @(posedge CLK); #1;
                if (toggle) bus.DOUT_READY = pat[i % 4];
                i++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            if (!toggle) check("done_cycle", 32'(ecnt), 32'(k + n + 2));
            check("busy_in_done", 32'(bus.BUSY), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_done"}, 32'(bus.DONE), 32'd0);
        check({tag, "_ren"}, 32'(bus.REN), 32'd0);
        check({tag, "_raddr"}, 32'(bus.RADDR), 32'd0);
        check({tag, "_dout"}, 32'(bus.DOUT), 32'd0);
        check({tag, "_valid"}, 32'(bus.DOUT_VALID), 32'd0);
        check({tag, "_csum"}, 32'(bus.CSUM), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, k2, ni, acc0, guard;
        logic [7:0] csum_exp;
        bus.START = 1'b0;
        bus.BASE_ADDR = '0;
        bus.LEN = '0;
        bus.DOUT_READY = 1'b1;
        for (int a = 0; a < 64; a++) ram[a] = 8'(a) + 8'h10;
        fork
            monitor();
        join_none

        // Reset state
        #12;
        check_reset_outputs("reset");
        @(posedge CLK); #1;
        RESETN = 1'b1;

        // BASE=0x04 LEN=5, READY high: bytes 0x14..0x18, valid from k+3
        push_byte(6'h04, 8'h14); push_byte(6'h05, 8'h15); push_byte(6'h06, 8'h16);
        push_byte(6'h07, 8'h17); push_byte(6'h08, 8'h18);
        start_xfer(6'h04, 7'd5, 1'b0, k);
        @(negedge CLK);
        check("t1_busy_k1", 32'(bus.BUSY), 32'd1);
        check("t1_ren_k1", 32'(bus.REN), 32'd1);
        check("t1_valid_k1", 32'(bus.DOUT_VALID), 32'd0);
        @(negedge CLK);
        check("t1_valid_k2", 32'(bus.DOUT_VALID), 32'd0);
        @(negedge CLK);
        check("t1_valid_k3", 32'(bus.DOUT_VALID), 32'd1);
        wait_done(k, 5, 1'b0);
`ifdef TPSRAM_RD_CSUM_EN
        csum_exp = 8'h6E;
`else
        csum_exp = 8'h00;
`endif
        check("t1_csum_done", 32'(bus.CSUM), 32'(csum_exp));
        @(negedge CLK);
        check("t1_done_pulse_end", 32'(bus.DONE), 32'd0);
        check("t1_csum_hold", 32'(bus.CSUM), 32'(csum_exp));

        // Address wrap: 0x3E, 0x3F, 0x00, 0x01
        push_byte(6'h3E, 8'h4E); push_byte(6'h3F, 8'h4F);
        push_byte(6'h00, 8'h10); push_byte(6'h01, 8'h11);
        start_xfer(6'h3E, 7'd4, 1'b0, k);
        wait_done(k, 4, 1'b0);

        // LEN=0: DONE next cycle, no read, BUSY stays low, CSUM cleared
        ni = n_issued;
        start_xfer(6'h10, 7'd0, 1'b0, k);
        @(negedge CLK);
        check("len0_done", 32'(bus.DONE), 32'd1);
        check("len0_busy", 32'(bus.BUSY), 32'd0);
        check("len0_ren", 32'(bus.REN), 32'd0);
        check("len0_csum", 32'(bus.CSUM), 32'd0);
        @(negedge CLK);
        check("len0_done_end", 32'(bus.DONE), 32'd0);
        check("len0_no_reads", 32'(n_issued - ni), 32'd0);

        // START while BUSY is ignored; START in the DONE cycle is taken
        push_xfer(6'h08, 6);
        start_xfer(6'h08, 7'd6, 1'b0, k);
        start_xfer(6'h30, 7'd3, 1'b1, k2);
        check("busy_start_busy", 32'(bus.BUSY), 32'd1);
        wait_done(k, 6, 1'b0);
        push_xfer(6'h20, 3);
        start_xfer(6'h20, 7'd3, 1'b1, k2);
        @(negedge CLK);
        check("chain_busy", 32'(bus.BUSY), 32'd1);
        check("chain_raddr", 32'(bus.RADDR), 32'h20);
        wait_done(k2, 3, 1'b0);

        // LEN=64 with READY toggling 1,0,0,1
        push_xfer(6'h05, 64);
        start_xfer(6'h05, 7'd64, 1'b0, k);
        wait_done(k, 64, 1'b1);
        bus.DOUT_READY = 1'b1;

        // Reset after byte 2 of an 8-byte transfer
        acc0 = n_accepted;
        push_xfer(6'h20, 8);
        start_xfer(6'h20, 7'd8, 1'b0, k);
        guard = 0;
        while (n_accepted < acc0 + 2 && guard < 50) begin
            @(posedge CLK); #2;
            guard++;
        end
        check("rst_mid_reached", 32'(n_accepted >= acc0 + 2), 32'd1);
        RESETN = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        push_xfer(6'h3A, 3);
        start_xfer(6'h3A, 7'd3, 1'b0, k);
        wait_done(k, 3, 1'b0);

        repeat (5) @(negedge CLK);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("exp_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
